// File: rtl/mips_cpu_bus_arbiter_pkg.sv
// rtl/mips_cpu_bus_arbiter_pkg.sv - shared types and constants for the CPU bus arbiter
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// rtl/mips_cpu_bus_arbiter_if.sv - CPU fetch/data ports and Avalon-style bus seen by the arbiter
interface mips_cpu_bus_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    // The arbiter owns the bus strobes and the per-port completion signals.
    modport master (
        input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
        input  waitrequest, readdata,
        output i_done, i_rdata, d_done, d_rdata,
        output address, write, read, writedata, byteenable
    );

    modport slave (
        output i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
        output waitrequest, readdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  address, write, read, writedata, byteenable
    );

endinterface

// File: rtl/mips_cpu_bus_arbiter_rr_pick.sv
// rtl/mips_cpu_bus_arbiter_rr_pick.sv - combinational grant selection between fetch and data ports
module mips_bus_rr_pick
    import mips_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic  i_req,
    input  logic  d_req,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant_port
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_port  = PORT_DATA;
        if (i_req && !d_req) begin
            grant_port = PORT_INSTR;
        end else if (i_req && d_req && ROUND_ROBIN && (last_grant == PORT_DATA)) begin
            grant_port = PORT_INSTR;
        end
    end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// rtl/mips_cpu_bus_arbiter.sv - shares one Avalon-style word bus between CPU fetch and load/store ports
module mips_cpu_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_cpu_bus_arbiter_if.master bus
);

    arb_state_t state, state_next;
    port_t      last_grant;
    logic       grant_valid;
    port_t      grant_port;
    logic       latch_instr, latch_data, complete;

    mips_bus_rr_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_port == PORT_INSTR) ? ARB_INSTR : ARB_DATA;
                end
            end
            default: begin
                if (!bus.waitrequest) begin
                    state_next = ARB_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        latch_instr = (state == ARB_IDLE) && grant_valid && (grant_port == PORT_INSTR);
        latch_data  = (state == ARB_IDLE) && grant_valid && (grant_port == PORT_DATA);
        complete    = (state != ARB_IDLE) && !bus.waitrequest;
    end

    // Bus fields are registered at grant so late requester changes cannot reach the slave.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant     <= PORT_DATA;
            bus.address    <= '0;
            bus.write      <= 1'b0;
            bus.read       <= 1'b0;
            bus.writedata  <= '0;
            bus.byteenable <= '0;
            bus.i_rdata    <= '0;
            bus.d_rdata    <= '0;
            bus.i_done     <= 1'b0;
            bus.d_done     <= 1'b0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            if (latch_instr) begin
                last_grant     <= PORT_INSTR;
                bus.address    <= bus.i_addr;
                bus.write      <= 1'b0;
                bus.read       <= 1'b1;
                bus.writedata  <= '0;
                bus.byteenable <= BYTEEN_WORD;
            end else if (latch_data) begin
                last_grant     <= PORT_DATA;
                bus.address    <= bus.d_addr;
                bus.write      <= bus.d_write;
                bus.read       <= !bus.d_write;
                bus.writedata  <= bus.d_wdata;
                bus.byteenable <= bus.d_byteenable;
            end else if (complete) begin
                bus.read  <= 1'b0;
                bus.write <= 1'b0;
                if (state == ARB_INSTR) begin
                    bus.i_rdata <= bus.readdata;
                    bus.i_done  <= 1'b1;
                end else begin
                    if (!bus.write) begin
                        bus.d_rdata <= bus.readdata;
                    end
                    bus.d_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb/tb_mips_cpu_bus_arbiter.sv - directed self-checking bench for mips_cpu_bus_arbiter
module tb_mips_cpu_bus_arbiter;
    import mips_bus_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_cpu_bus_arbiter_if bus_rr ();
    mips_cpu_bus_arbiter_if bus_fp ();

    mips_cpu_bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
    mips_cpu_bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus_rr.i_req = 0; bus_rr.i_addr = 0; bus_rr.d_req = 0; bus_rr.d_write = 0;
        bus_rr.d_addr = 0; bus_rr.d_wdata = 0; bus_rr.d_byteenable = 0;
        bus_rr.waitrequest = 0; bus_rr.readdata = 0;
        bus_fp.i_req = 0; bus_fp.i_addr = 0; bus_fp.d_req = 0; bus_fp.d_write = 0;
        bus_fp.d_addr = 0; bus_fp.d_wdata = 0; bus_fp.d_byteenable = 0;
        bus_fp.waitrequest = 0; bus_fp.readdata = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_rr.read, bus_rr.write, bus_rr.i_done, bus_rr.d_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b exp 0000", {bus_rr.read, bus_rr.write, bus_rr.i_done, bus_rr.d_done});
        end
        checks++;
        if ({bus_rr.address, bus_rr.writedata, bus_rr.byteenable} !== 68'h0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%b exp 0", bus_rr.address, bus_rr.writedata, bus_rr.byteenable);
        end
        checks++;
        if ({bus_rr.i_rdata, bus_rr.d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0", bus_rr.i_rdata, bus_rr.d_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        bus_rr.i_req = 1; bus_rr.i_addr = 32'hBFC00000; bus_rr.waitrequest = 0; bus_rr.readdata = 32'h8C220004;
        @(negedge clk);
        checks++;
        if ({bus_rr.read, bus_rr.write} !== 2'b10 || bus_rr.address !== 32'hBFC00000) begin
            errors++; $display("FAIL fetch_strobe got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=bfc00000", bus_rr.read, bus_rr.write, bus_rr.address);
        end
        checks++;
        if (bus_rr.byteenable !== 4'b1111 || bus_rr.writedata !== 32'h0 || bus_rr.i_done !== 1'b0) begin
            errors++; $display("FAIL fetch_fields got be=%b wd=%h done=%b exp 1111/0/0", bus_rr.byteenable, bus_rr.writedata, bus_rr.i_done);
        end
        bus_rr.i_req = 0;
        @(negedge clk);
        checks++;
        if (bus_rr.i_done !== 1'b1 || bus_rr.i_rdata !== 32'h8C220004 || bus_rr.read !== 1'b0) begin
            errors++; $display("FAIL fetch_done got done=%b rdata=%h rd=%b exp 1/8c220004/0", bus_rr.i_done, bus_rr.i_rdata, bus_rr.read);
        end
        bus_rr.readdata = 32'h11111111;
        @(negedge clk);
        checks++;
        if (bus_rr.i_done !== 1'b0 || bus_rr.i_rdata !== 32'h8C220004 || bus_rr.d_done !== 1'b0) begin
            errors++; $display("FAIL fetch_hold got done=%b rdata=%h exp 0/8c220004", bus_rr.i_done, bus_rr.i_rdata);
        end
    endtask

    task automatic test_load_wait();
        int done_cnt;
        bus_rr.d_req = 1; bus_rr.d_write = 0; bus_rr.d_addr = 32'h00001000;
        bus_rr.d_byteenable = 4'b1111; bus_rr.waitrequest = 1; bus_rr.readdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.read !== 1'b1 || bus_rr.address !== 32'h00001000 || bus_rr.d_done !== 1'b0) begin
                errors++; $display("FAIL load_hold[%0d] got rd=%b addr=%h done=%b exp 1/00001000/0", i, bus_rr.read, bus_rr.address, bus_rr.d_done);
            end
            if (i == 0) bus_rr.d_req = 0;
            if (i == 3) begin bus_rr.waitrequest = 0; bus_rr.readdata = 32'h02210000; end
        end
        @(negedge clk);
        checks++;
        if (bus_rr.d_done !== 1'b1 || bus_rr.d_rdata !== 32'h02210000 || bus_rr.read !== 1'b0) begin
            errors++; $display("FAIL load_done got done=%b rdata=%h rd=%b exp 1/02210000/0", bus_rr.d_done, bus_rr.d_rdata, bus_rr.read);
        end
        bus_rr.readdata = 32'hFFFFFFFF;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done_cnt += int'(bus_rr.d_done);
        end
        checks++;
        if (done_cnt != 0 || bus_rr.d_rdata !== 32'h02210000) begin
            errors++; $display("FAIL load_single_done got extra=%0d rdata=%h exp 0/02210000", done_cnt, bus_rr.d_rdata);
        end
    endtask

    task automatic test_store();
        bus_rr.d_req = 1; bus_rr.d_write = 1; bus_rr.d_addr = 32'h00002000;
        bus_rr.d_wdata = 32'hDEADBEEF; bus_rr.d_byteenable = 4'b0011;
        bus_rr.waitrequest = 0; bus_rr.readdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({bus_rr.write, bus_rr.read} !== 2'b10 || bus_rr.writedata !== 32'hDEADBEEF || bus_rr.byteenable !== 4'b0011 || bus_rr.address !== 32'h00002000) begin
            errors++; $display("FAIL store_bus got wr=%b rd=%b wd=%h be=%b addr=%h exp 1/0/deadbeef/0011/00002000", bus_rr.write, bus_rr.read, bus_rr.writedata, bus_rr.byteenable, bus_rr.address);
        end
        bus_rr.d_req = 0;
        @(negedge clk);
        checks++;
        if (bus_rr.d_done !== 1'b1 || bus_rr.d_rdata !== 32'h02210000 || bus_rr.write !== 1'b0) begin
            errors++; $display("FAIL store_done got done=%b rdata=%h wr=%b exp 1/02210000/0", bus_rr.d_done, bus_rr.d_rdata, bus_rr.write);
        end
        @(negedge clk);
        checks++;
        if (bus_rr.byteenable !== 4'b0011 || bus_rr.writedata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_keep got be=%b wd=%h exp 0011/deadbeef", bus_rr.byteenable, bus_rr.writedata);
        end
        bus_rr.d_write = 0;
    endtask

    task automatic test_late_addr();
        bus_rr.i_req = 1; bus_rr.i_addr = 32'hA0000000; bus_rr.waitrequest = 1; bus_rr.readdata = 32'h00ABCDEF;
        @(negedge clk);
        bus_rr.i_req = 0; bus_rr.i_addr = 32'hFFFFFFFC;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.address !== 32'hA0000000 || bus_rr.read !== 1'b1) begin
                errors++; $display("FAIL late_addr[%0d] got addr=%h rd=%b exp a0000000/1", i, bus_rr.address, bus_rr.read);
            end
        end
        bus_rr.waitrequest = 0;
        @(negedge clk);
        checks++;
        if (bus_rr.i_done !== 1'b1 || bus_rr.i_rdata !== 32'h00ABCDEF) begin
            errors++; $display("FAIL late_done got done=%b rdata=%h exp 1/00abcdef", bus_rr.i_done, bus_rr.i_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [3:0] rr_seq;
        logic [3:0] fp_seq;
        int         rr_n;
        int         fp_n;
        logic       both_done;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_rr.i_req = 1; bus_rr.i_addr = 32'h100; bus_rr.d_req = 1; bus_rr.d_write = 0; bus_rr.d_addr = 32'h200;
        bus_rr.d_byteenable = 4'b1111; bus_rr.waitrequest = 0;
        bus_fp.i_req = 1; bus_fp.i_addr = 32'h100; bus_fp.d_req = 1; bus_fp.d_write = 0; bus_fp.d_addr = 32'h200;
        bus_fp.d_byteenable = 4'b1111; bus_fp.waitrequest = 0;
        rr_seq = '0; fp_seq = '0; rr_n = 0; fp_n = 0; both_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_rr.read && rr_n < 4) begin rr_seq[rr_n] = (bus_rr.address == 32'h200); rr_n++; end
            if (bus_fp.read && fp_n < 4) begin fp_seq[fp_n] = (bus_fp.address == 32'h200); fp_n++; end
            if (bus_rr.i_done && bus_rr.d_done) both_done = 1'b1;
        end
        checks++;
        if (rr_n != 4 || rr_seq !== 4'b1010) begin
            errors++; $display("FAIL rr_order got n=%0d seq(bit0 first,1=D)=%b exp 4/1010", rr_n, rr_seq);
        end
        checks++;
        if (fp_n != 4 || fp_seq !== 4'b1111) begin
            errors++; $display("FAIL fixed_order got n=%0d seq=%b exp 4/1111", fp_n, fp_seq);
        end
        checks++;
        if (both_done !== 1'b0) begin
            errors++; $display("FAIL done_overlap got %b exp 0", both_done);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        bus_rr.d_req = 1; bus_rr.d_write = 1; bus_rr.d_addr = 32'h300; bus_rr.d_wdata = 32'h5A5A5A5A;
        bus_rr.d_byteenable = 4'b1111; bus_rr.waitrequest = 1;
        @(negedge clk);
        checks++;
        if (bus_rr.write !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got wr=%b exp 1", bus_rr.write);
        end
        bus_rr.d_req = 0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus_rr.read, bus_rr.write} !== 2'b00) begin
            errors++; $display("FAIL midrst_async got rd=%b wr=%b exp 0/0", bus_rr.read, bus_rr.write);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_rr.waitrequest = 0;
        checks++;
        if (dut_rr.state !== ARB_IDLE || {bus_rr.i_rdata, bus_rr.d_rdata} !== 64'h0) begin
            errors++; $display("FAIL midrst_state got st=%0d rdata=%h/%h exp 0/0/0", dut_rr.state, bus_rr.i_rdata, bus_rr.d_rdata);
        end
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done_cnt += int'(bus_rr.d_done) + int'(bus_rr.i_done) + int'(bus_rr.write);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL midrst_nodone got %0d exp 0", done_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_load_wait();
        test_store();
        test_late_addr();
        test_contention();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Shares the single Avalon-style memory bus of `mips_cpu_bus` between the CPU's instruction-fetch port and its load/store data port. Each port issues one word transaction at a time. The arbiter grants one port, drives the bus from registered copies of that port's request, and honours `waitrequest`. It returns read data and a one-cycle `done` pulse to the granted port. It sits between the CPU core datapath and `mips_cpu_ram` (or any slave using the same bus).

## Interface
- `ROUND_ROBIN`, 1: 1 = alternate grants when both ports request; 0 = data port always wins ties.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_req` in 1: fetch request, level.
- `i_addr` in 32: fetch address.
- `i_done` out 1: one-cycle pulse; fetch transaction finished.
- `i_rdata` out 32: fetched word, valid while `i_done`=1 and held until next `i_done`.
- `d_req` in 1: data request, level.
- `d_write` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_byteenable` in 4: store/load byte lanes.
- `d_done` out 1: one-cycle pulse; data transaction finished.
- `d_rdata` out 32: load word, valid while `d_done`=1 and held until next `d_done`.
- `address` out 32: bus address.
- `write` out 1: bus write strobe.
- `read` out 1: bus read strobe.
- `waitrequest` in 1: slave stall.
- `writedata` out 32: bus write data.
- `byteenable` out 4: bus byte lanes.
- `readdata` in 32: bus read data.

## Operation
- **States:** ARB_IDLE, ARB_INSTR, ARB_DATA. Reset state is ARB_IDLE.
- **ARB_IDLE, grant decision:** evaluated at each rising edge.
  - Only one `*_req` high: grant that port.
  - Both high, `ROUND_ROBIN`=1: grant the port not in `last_grant`.
  - Both high, `ROUND_ROBIN`=0: grant data.
  - On grant: latch address, write, writedata and byteenable into bus registers; set `last_grant`; enter ARB_INSTR or ARB_DATA.
- **Instruction grant fields:** `read`=1, `write`=0, `byteenable`=4'b1111, `writedata`=0.
- **Data grant fields:** `write`=`d_write`, `read`=!`d_write`, remaining fields taken from the `d_*` inputs.
- **ARB_INSTR / ARB_DATA:** bus outputs are held constant while `waitrequest`=1; there is no timeout. At the first rising edge with `waitrequest`=0:
  - capture `readdata` into the granted port's `*_rdata` (loads and fetches only; a store leaves `d_rdata` unchanged);
  - assert that port's `*_done` for the next cycle;
  - drop `read`/`write` to 0;
  - return to ARB_IDLE.
- **Requester rule:** during its `*_done` cycle, a port must deassert `*_req` or present a new request. The arbiter samples again at the end of that cycle, which is its ARB_IDLE cycle.
- **Bus outputs outside a grant:** `read`=`write`=0. `address`, `writedata` and `byteenable` keep their last values.
- **Reset values:** all outputs 0, including `i_rdata`, `d_rdata` and `byteenable`. `last_grant`=DATA, so the first contested grant goes to fetch.
- **Reset mid-transaction:** `read`/`write` drop immediately (asynchronously). No `*_done` is issued and the transaction is abandoned.
- **Request changes after grant:** changes to `*_addr` or `*_wdata` after grant are ignored because the bus is driven from the registered copies.

## Timing
- **Handshake:** `*_req` sampled high at edge k gives a bus strobe during cycle k..k+1.
- **Completion:** with zero wait states the transfer completes at edge k+1, `*_done` is high during k+1..k+2, and ARB_IDLE re-samples at edge k+2.
- **Latency:** request-to-done is 1 + W cycles, where W is the number of waitrequest cycles.
- **Throughput:** at most one transaction per 2 + W cycles.
- **Done pulses:** `i_done` and `d_done` are never high in the same cycle.
- **Registered outputs:** all outputs come from registers, so there is no combinational path from any input to any output.

## Structure
- **Package `mips_bus_pkg`:**
  - `arb_state_t` enum {ARB_IDLE, ARB_INSTR, ARB_DATA};
  - `port_t` enum {PORT_INSTR, PORT_DATA};
  - constant `BYTEEN_WORD` = 4'b1111.
- **Sub-module `mips_bus_rr_pick`:** combinational; inputs `i_req`, `d_req`, `last_grant`, `ROUND_ROBIN`; outputs `grant_valid` and `grant_port`. Everything else stays in the top module.

## Test plan
- **Reset then fetch:** `i_req`=1, `i_addr`=32'hBFC00000, `waitrequest`=0. Expected: `read`=1 and `address`=BFC00000 one cycle after the sample edge; `byteenable`=1111. Then, with `readdata`=32'h8C220004, `i_done`=1 and `i_rdata`=8C220004 the following cycle.
- **Load with 3 wait states:** `d_req`=1, `d_write`=0, `d_addr`=32'h00001000. Expected: `read` held high with `address` stable for 4 cycles; `d_done` exactly once; `d_rdata`=`readdata` as presented on the accepting edge (e.g. 32'h02210000).
- **Store:** `d_write`=1, `d_wdata`=32'hDEADBEEF, `d_byteenable`=4'b0011. Expected: `write`=1, `read`=0, `writedata`=DEADBEEF, `byteenable`=0011; `d_rdata` unchanged after `d_done`.
- **Contention, `ROUND_ROBIN`=1:** both ports request continuously. Expected: grants I, D, I, D; first grant after reset is I. With `ROUND_ROBIN`=0: every grant is D while `d_req` is high.
- **Reset mid-transaction:** assert `reset` while `waitrequest`=1 in ARB_DATA. Expected: `read`/`write`=0 before the next edge; no `d_done`; state ARB_IDLE; `i_rdata`/`d_rdata`=0.
- **Late address change:** change `i_addr` after grant while `waitrequest`=1. Expected: `address` keeps the originally latched value.
